// File: rtl/bcd2421_xs3_sequencer.sv
// Walks an NDIG-digit 2421 operand through one shared external 2421->excess-3
// converter, one digit per clock. Define BCD2421_ERRCHK_EN to flag illegal 2421 codes.
module bcd2421_xs3_sequencer #(
    parameter int NDIG = 4,
    parameter int IDXW = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4*NDIG-1:0] in_word_i,
    output logic [3:0]        conv_in_o,
    input  logic [3:0]        conv_out_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [4*NDIG-1:0] out_word_o,
    output logic [NDIG-1:0]   out_err_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [NDIG-1:0][3:0]  op_q, op_d;
    logic [NDIG-1:0][3:0]  word_q, word_d;
    logic                  in_ready_q, in_ready_d;
    logic [3:0]            cur_dig;
`ifdef BCD2421_ERRCHK_EN
    logic [NDIG-1:0]       err_q, err_d;

    function automatic logic illegal_2421(input logic [3:0] d);
        return (d >= 4'd5) && (d <= 4'd10);
    endfunction
`endif

    // Compare-based digit select keeps the index width independent of NDIG.
    always_comb begin
        cur_dig = 4'd0;
        for (int i = 0; i < NDIG; i++)
            if (idx_q == IDXW'(i)) cur_dig = op_q[i];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        word_d  = word_q;
`ifdef BCD2421_ERRCHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    op_d    = in_word_i;
                    idx_d   = '0;
                    word_d  = '0;
`ifdef BCD2421_ERRCHK_EN
                    err_d   = '0;
`endif
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        word_d[i] = conv_out_i;
`ifdef BCD2421_ERRCHK_EN
                        err_d[i]  = illegal_2421(cur_dig);
`endif
                    end
                end
                if (idx_q == IDXW'(NDIG-1)) state_d = S_HOLD;
                else                        idx_d   = idx_q + 1'b1;
            end
            S_HOLD: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // in_ready is registered so it reads 0 while reset is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            op_q       <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef BCD2421_ERRCHK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= '0;
        else         err_q <= err_d;
    end
    assign out_err_o = err_q;
`else
    assign out_err_o = '0;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == S_HOLD);
    assign busy_o      = (state_q != S_IDLE);
    assign out_word_o  = word_q;
    assign conv_in_o   = (state_q == S_CONV) ? cur_dig : 4'd0;

endmodule

// File: tb/tb_bcd2421_xs3_sequencer.sv
// Directed bench: table of 2421 words with hand-computed excess-3 results, plus
// reset-abort, backpressure and back-to-back sequences.
module tb_bcd2421_xs3_sequencer;

    localparam int NDIG = 4;
    localparam int IDXW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_word;
    logic [3:0]        conv_in;
    logic [3:0]        conv_out;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] out_word;
    logic [NDIG-1:0]   out_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External converter: weighted 2421 value plus 3 (illegal codes included).
    always_comb begin
        conv_out = 4'((conv_in[3] ? 2 : 0) + (conv_in[2] ? 4 : 0) +
                      (conv_in[1] ? 2 : 0) + (conv_in[0] ? 1 : 0) + 3);
    end

    bcd2421_xs3_sequencer #(.NDIG(NDIG), .IDXW(IDXW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word),
        .conv_in_o(conv_in), .conv_out_i(conv_out),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_word_o(out_word), .out_err_o(out_err), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_word;
        logic [3:0]  exp_err;
    } vec_t;

`ifdef BCD2421_ERRCHK_EN
    localparam logic [3:0] ERR_1005 = 4'b0001;
    localparam logic [3:0] ERR_9876 = 4'b1111;
`else
    localparam logic [3:0] ERR_1005 = 4'b0000;
    localparam logic [3:0] ERR_9876 = 4'b0000;
`endif

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk({name, " ready"}, 32'(in_ready), 32'd1);
    endtask

    // Accepts one word at the next edge; returns the cycles until out_valid.
    task automatic send(input logic [15:0] w, output int lat);
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    endtask

    vec_t vecs[6];
    int   lat;
    int   bad;
    int   acc;
    int   nout;
    int   acc_cyc[2];
    logic [15:0] outs[2];

    initial begin
        vecs[0] = '{16'h4321, 16'h7654, 4'b0000};
        vecs[1] = '{16'hFB41, 16'hC874, 4'b0000};
        vecs[2] = '{16'h0000, 16'h3333, 4'b0000};
        vecs[3] = '{16'hFFFF, 16'hCCCC, 4'b0000};
        vecs[4] = '{16'h1005, 16'h4338, ERR_1005};
        vecs[5] = '{16'h9876, 16'h65A9, ERR_9876};

        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready",  32'(in_ready),  32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst out_word",  32'(out_word),  32'd0);
        chk("rst out_err",   32'(out_err),   32'd0);
        chk("rst conv_in",   32'(conv_in),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            wait_ready($sformatf("vec%0d", v));
            send(vecs[v].word, lat);
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'(NDIG));
            chk($sformatf("vec%0d word", v), 32'(out_word), 32'(vecs[v].exp_word));
            chk($sformatf("vec%0d err", v), 32'(out_err), 32'(vecs[v].exp_err));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("vec%0d release", v), 32'(out_valid), 32'd0);
        end

        // Reset partway through CONV: two digits written, then abort.
        wait_ready("abort");
        in_word = 16'h4321; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy",      32'(busy),      32'd0);
        chk("abort out_word",  32'(out_word),  32'd0);
        chk("abort in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort in_ready after", 32'(in_ready), 32'd1);
        bad = 0;
        repeat (8) begin @(negedge clk); if (out_valid || busy) bad++; end
        chk("abort no stale output", 32'(bad), 32'd0);

        // Backpressure: output held, new in_valid pulses ignored.
        wait_ready("bp");
        send(16'h4321, lat);
        chk("bp latency", 32'(lat), 32'(NDIG));
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_word  = 16'hFFFF;
            @(negedge clk);
            if (!out_valid || in_ready || out_word !== 16'h7654) bad++;
        end
        in_valid = 1'b0;
        chk("bp stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp idle busy",   32'(busy),      32'd0);
        chk("bp idle valid",  32'(out_valid), 32'd0);
        chk("bp idle ready",  32'(in_ready),  32'd1);
        chk("bp word retain", 32'(out_word),  32'h7654);

        // Back-to-back words with in_valid and out_ready held high.
        acc = 0; nout = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        in_word = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && nout < 2; c++) begin
            if (acc == 1) in_word = 16'hFFFF;
            if (acc == 2) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (acc < 2) acc_cyc[acc] = c;
                acc++;
            end
            @(negedge clk);
            if (out_valid && nout < 2) begin outs[nout] = out_word; nout++; end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b outputs",  32'(nout), 32'd2);
        chk("b2b word0",    32'(outs[0]), 32'h3333);
        chk("b2b word1",    32'(outs[1]), 32'hCCCC);
        chk("b2b spacing",  32'(acc_cyc[1] - acc_cyc[0]), 32'(NDIG + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
